// File: rtl/cascade_down_counter.sv
// Cascadable loadable down-counter built from 4-bit nibble stages with a trickle
// borrow chain, borrow-out for chaining and optional auto-reload on underflow.

module cascade_down_counter_nibble (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       dec,
    input  logic       wrap,
    input  logic       auto_reload,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       zero
);
    logic [3:0] rld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 4'h0;
            rld <= 4'h0;
        end else if (load) begin
            q   <= d;
            rld <= d;
        end else if (wrap) begin
            // Whole counter underflows: every nibble takes its share of the reload target.
            q <= auto_reload ? rld : 4'hF;
        end else if (dec) begin
            q <= q - 4'd1;
        end
    end

    assign zero = (q == 4'h0);
endmodule

module cascade_down_counter #(
    parameter int STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  CLR_n,
    input  logic [4*STAGES-1:0]   D,
    input  logic                  LOAD_n,
    input  logic                  ENP,
    input  logic                  ENT,
    input  logic                  AUTO_RELOAD,
    output logic [4*STAGES-1:0]   Q,
    output logic                  BO,
    output logic                  TC_PULSE
);
    logic [STAGES-1:0][3:0] q_nib;
    logic [STAGES-1:0]      zero;
    logic [STAGES:0]        borrow;
    logic                   count;
    logic                   underflow;

    // borrow[k] is high when every nibble below k is zero.
    assign borrow[0] = 1'b1;
    assign count     = LOAD_n & ENP & ENT;
    assign underflow = count & borrow[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign borrow[k+1] = borrow[k] & zero[k];

        cascade_down_counter_nibble u_nib (
            .clk         (CLK),
            .rst_n       (CLR_n),
            .load        (~LOAD_n),
            .dec         (count & borrow[k]),
            .wrap        (underflow),
            .auto_reload (AUTO_RELOAD),
            .d           (D[4*k +: 4]),
            .q           (q_nib[k]),
            .zero        (zero[k])
        );
    end

    assign Q  = q_nib;
    assign BO = ENT & borrow[STAGES];

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n)
            TC_PULSE <= 1'b0;
        else
            TC_PULSE <= underflow;
    end
endmodule

// File: tb/tb_cascade_down_counter.sv
// Scoreboard bench: driver pushes model predictions per edge, monitor pops and compares.

module tb_cascade_down_counter;
    logic        CLK = 1'b0;
    logic        CLR_n = 1'b0;
    logic [7:0]  D = '0;
    logic        LOAD_n = 1'b1, ENP = 1'b0, ENT = 1'b0, AUTO_RELOAD = 1'b0;
    logic [7:0]  Q;
    logic        BO, TC_PULSE;

    logic [15:0] c_d = '0;
    logic        c_load_n = 1'b1, c_enp = 1'b0;
    logic [7:0]  c_q_lo, c_q_hi;
    logic        c_bo_lo, c_bo_hi, c_tc_lo, c_tc_hi;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  q;
        logic        tc;
        logic        bo;
        logic [15:0] cq;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int unsigned m_q, m_rld, m_c;
    bit          m_tc;

    always #5 CLK = ~CLK;

    cascade_down_counter #(.STAGES(2)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
        .AUTO_RELOAD(AUTO_RELOAD), .Q(Q), .BO(BO), .TC_PULSE(TC_PULSE)
    );

    cascade_down_counter #(.STAGES(2)) u_lo (
        .CLK(CLK), .CLR_n(CLR_n), .D(c_d[7:0]), .LOAD_n(c_load_n), .ENP(c_enp), .ENT(1'b1),
        .AUTO_RELOAD(1'b0), .Q(c_q_lo), .BO(c_bo_lo), .TC_PULSE(c_tc_lo)
    );

    cascade_down_counter #(.STAGES(2)) u_hi (
        .CLK(CLK), .CLR_n(CLR_n), .D(c_d[15:8]), .LOAD_n(c_load_n), .ENP(c_enp), .ENT(c_bo_lo),
        .AUTO_RELOAD(1'b0), .Q(c_q_hi), .BO(c_bo_hi), .TC_PULSE(c_tc_hi)
    );

    task automatic check(string name, int unsigned act, int unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit load_n, bit [7:0] d, bit enp, bit ent, bit ar,
                        bit cl_n, bit [15:0] cd, bit cenp);
        exp_t e;
        @(negedge CLK);
        LOAD_n = load_n; D = d; ENP = enp; ENT = ent; AUTO_RELOAD = ar;
        c_load_n = cl_n; c_d = cd; c_enp = cenp;
        if (!load_n) begin
            m_q = d; m_rld = d; m_tc = 0;
        end else if (enp && ent) begin
            if (m_q == 0) begin
                m_q  = ar ? m_rld : 255;
                m_tc = 1;
            end else begin
                m_q  = m_q - 1;
                m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
        if (!cl_n)     m_c = cd;
        else if (cenp) m_c = (m_c + 65535) % 65536;
        e.q = m_q[7:0]; e.tc = m_tc; e.bo = ent && (m_q == 0); e.cq = m_c[15:0];
        sb.push_back(e);
    endtask

    task automatic dstep(bit load_n, bit [7:0] d, bit enp, bit ent, bit ar);
        step(load_n, d, enp, ent, ar, 1'b1, 16'h0, 1'b0);
    endtask

    // Mid-cycle asynchronous clear with inputs parked in hold.
    task automatic reset_pulse();
        @(negedge CLK);
        LOAD_n = 1'b1; ENP = 1'b0; c_load_n = 1'b1; c_enp = 1'b0; ENT = 1'b1;
        #2 CLR_n = 1'b0;
        #1 check("rst_q", Q, 0);
        check("rst_tc", TC_PULSE, 0);
        check("rst_bo_ent1", BO, 1);
        ENT = 1'b0;
        #1 check("rst_bo_ent0", BO, 0);
        check("rst_casc", {c_q_hi, c_q_lo}, 0);
        #1 CLR_n = 1'b1;
        m_q = 0; m_rld = 0; m_tc = 0; m_c = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("q", Q, e.q);
                check("tc_pulse", TC_PULSE, e.tc);
                check("bo", BO, e.bo);
                check("cascade_q", {c_q_hi, c_q_lo}, e.cq);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL timeout: got no finish expected finish by 400000");
        $fatal(1, "timeout");
    end

    initial begin : driver
        m_q = 0; m_rld = 0; m_tc = 0; m_c = 0;
        #3;
        check("por_q", Q, 0);
        check("por_tc", TC_PULSE, 0);
        @(negedge CLK); CLR_n = 1'b1;

        // Clear mid-count from 0x5A
        dstep(0, 8'h5A, 0, 0, 0);
        dstep(1, 8'h00, 0, 1, 0);
        reset_pulse();

        // Wrap to all-ones
        dstep(0, 8'h03, 0, 0, 0);
        repeat (4) dstep(1, 8'h00, 1, 1, 0);

        // Auto-reload
        dstep(0, 8'h02, 0, 0, 1);
        repeat (6) dstep(1, 8'h00, 1, 1, 1);

        // Nibble borrow, then paused at zero
        dstep(0, 8'h10, 0, 0, 0);
        dstep(1, 8'h00, 1, 1, 0);
        dstep(0, 8'h00, 0, 0, 0);
        repeat (3) dstep(1, 8'h00, 0, 1, 0);

        // Load beats count
        dstep(0, 8'h7C, 1, 1, 1);
        dstep(1, 8'h00, 1, 1, 0);

        // Reload value of zero with auto-reload pins Q at 0
        dstep(0, 8'h00, 0, 0, 1);
        repeat (4) dstep(1, 8'h00, 1, 1, 1);

        // Cascade from zero through the 16-bit wrap and a few hi-nibble borrows
        step(1, 8'h00, 0, 0, 0, 0, 16'h0000, 0);
        repeat (300) step(1, 8'h00, 0, 0, 0, 1, 16'h0, 1);
        step(1, 8'h00, 0, 0, 0, 0, 16'h0102, 0);
        repeat (8) step(1, 8'h00, 0, 0, 0, 1, 16'h0, 1);

        // Random traffic with rare loads of small values to hit underflow often
        for (int i = 0; i < 2000; i++) begin
            bit ld, cld;
            ld  = ($urandom_range(0, 15) == 0);
            cld = ($urandom_range(0, 31) == 0);
            step(!ld, 8'($urandom_range(0, 12)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, 1'($urandom),
                 !cld, 16'($urandom), $urandom_range(0, 3) != 0);
            if (i == 1000) reset_pulse();
        end

        repeat (3) @(posedge CLK);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
